// File: rtl/stream_omega_pkg.sv
// Shared widths and per-input FSM state for the credit admission scheduler
// that sits in front of stream_omega_net.
package stream_omega_pkg;

  function automatic int sel_width(input int num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

  function automatic int cnt_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } in_state_e;

endpackage

// File: rtl/stream_omega_credit_sched_if.sv
// Handshake bundle between requesters, the scheduler, the net and the sinks.
// master drives requests, net readiness and credit returns; slave is the scheduler.
interface stream_omega_credit_sched_if
  import stream_omega_pkg::*;
#(
  parameter int NumInp     = 4,
  parameter int NumOut     = 4,
  parameter int MaxCredits = 2
);
  localparam int SelWidth = sel_width(NumOut);
  localparam int CntWidth = cnt_width(MaxCredits);

  logic [NumInp-1:0]          req_valid;
  logic [NumInp*SelWidth-1:0] req_sel;
  logic [NumInp-1:0]          req_ready;
  logic [NumInp-1:0]          net_valid;
  logic [NumInp-1:0]          net_ready;
  logic [NumOut-1:0]          cred_ret;
  logic [NumOut*CntWidth-1:0] credits;
  logic                       busy;

  modport master (
    output req_valid, req_sel, net_ready, cred_ret,
    input  req_ready, net_valid, credits, busy
  );

  modport slave (
    input  req_valid, req_sel, net_ready, cred_ret,
    output req_ready, net_valid, credits, busy
  );
endinterface

// File: rtl/stream_omega_credit_out.sv
// One net output: credit counter, round-robin pointer and the pick among
// the inputs currently requesting this output.
module stream_omega_credit_out
  import stream_omega_pkg::*;
#(
  parameter int NumInp     = 4,
  parameter int MaxCredits = 2,
  parameter int CntWidth   = cnt_width(MaxCredits)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumInp-1:0]   cand,
  input  logic                ret,
  output logic [NumInp-1:0]   grant,
  output logic [CntWidth-1:0] credits
);
  localparam int PtrWidth = sel_width(NumInp);
  localparam logic [CntWidth-1:0] Full = CntWidth'(MaxCredits);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [PtrWidth-1:0] rr_q, rr_d;
  logic                take;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant = '0;
    rr_d  = rr_q;
    idx   = 0;
    if (cnt_q != '0) begin
      for (int k = 0; k < NumInp; k++) begin
        idx = (int'(rr_q) + k) % NumInp;
        if (grant == '0 && cand[idx]) begin
          grant[idx] = 1'b1;
          rr_d       = PtrWidth'((idx + 1) % NumInp);
        end
      end
    end
  end

  assign take = |grant;

  // A return arriving with the pool already full is a sink error; hold at full.
  always_comb begin
    cnt_d = cnt_q;
    case ({take, ret})
      2'b10:   cnt_d = cnt_q - 1'b1;
      2'b01:   cnt_d = (cnt_q == Full) ? Full : cnt_q + 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= Full;
      rr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
    end
  end

  assign credits = cnt_q;

  ret_below_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    ret |-> cnt_q != Full);

endmodule

// File: rtl/stream_omega_credit_sched.sv
// Credit-based admission scheduler: per-input IDLE/GRANTED FSMs feeding
// per-output credit pools with round-robin arbitration.
module stream_omega_credit_sched
  import stream_omega_pkg::*;
#(
  parameter int NumInp     = 4,
  parameter int NumOut     = 4,
  parameter int MaxCredits = 2
) (
  input logic                         clk_i,
  input logic                         rst_i,
  stream_omega_credit_sched_if.slave  bus
);
  localparam int SelWidth = sel_width(NumOut);
  localparam int CntWidth = cnt_width(MaxCredits);

  in_state_e                         state_q [NumInp];
  in_state_e                         state_d [NumInp];
  logic [SelWidth-1:0]               sel_q   [NumInp];
  logic [NumOut-1:0][NumInp-1:0]     cand;
  logic [NumOut-1:0][NumInp-1:0]     grant;
  logic [NumOut-1:0][CntWidth-1:0]   cnt;
  logic [NumInp-1:0]                 granted;

  // An out-of-range destination matches no output and is never a candidate.
  always_comb begin
    cand = '0;
    for (int j = 0; j < NumOut; j++) begin
      for (int i = 0; i < NumInp; i++) begin
        cand[j][i] = (state_q[i] == IDLE) && bus.req_valid[i] &&
                     (int'(bus.req_sel[i*SelWidth +: SelWidth]) == j);
      end
    end
  end

  for (genvar j = 0; j < NumOut; j++) begin : g_out
    stream_omega_credit_out #(
      .NumInp     (NumInp),
      .MaxCredits (MaxCredits),
      .CntWidth   (CntWidth)
    ) u_out (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cand    (cand[j]),
      .ret     (bus.cred_ret[j]),
      .grant   (grant[j]),
      .credits (cnt[j])
    );
  end

  always_comb begin
    granted = '0;
    for (int j = 0; j < NumOut; j++) granted |= grant[j];
  end

  always_comb begin
    bus.net_valid = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NumInp; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (granted[i]) state_d[i] = GRANTED;
        end
        GRANTED: begin
          bus.net_valid[i] = 1'b1;
          bus.req_ready[i] = bus.net_ready[i];
          if (bus.net_ready[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumInp; i++) begin
      if (rst_i) begin
        state_q[i] <= IDLE;
        sel_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        if (granted[i]) sel_q[i] <= bus.req_sel[i*SelWidth +: SelWidth];
      end
    end
  end

  // Status views come only from registered state.
  always_comb begin
    bus.busy = 1'b0;
    for (int j = 0; j < NumOut; j++) begin
      bus.credits[j*CntWidth +: CntWidth] = cnt[j];
      if (cnt[j] != CntWidth'(MaxCredits)) bus.busy = 1'b1;
    end
    for (int i = 0; i < NumInp; i++) begin
      if (state_q[i] == GRANTED) bus.busy = 1'b1;
    end
  end

  for (genvar i = 0; i < NumInp; i++) begin : g_chk
    stable_while_granted_a: assert property (@(posedge clk_i) disable iff (rst_i)
      state_q[i] == GRANTED |->
        bus.req_valid[i] && bus.req_sel[i*SelWidth +: SelWidth] == sel_q[i]);
    sel_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.req_valid[i] |-> int'(bus.req_sel[i*SelWidth +: SelWidth]) < NumOut);
  end

endmodule
